// File: rtl/instruction_fetch_queue_if.sv
// Fetch queue bus bundle: PC side, instruction memory side and decode side.
// master is the fetch queue itself; slave is its environment.
interface instruction_fetch_queue_if;
  logic [31:0] pc_addr;
  logic        redirect;
  logic        pc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    input  pc_addr,
    input  redirect,
    input  imem_rdata,
    input  instr_ready,
    output pc_stall,
    output imem_req,
    output imem_addr,
    output instr,
    output instr_pc,
    output instr_valid
  );

  modport slave (
    output pc_addr,
    output redirect,
    output imem_rdata,
    output instr_ready,
    input  pc_stall,
    input  imem_req,
    input  imem_addr,
    input  instr,
    input  instr_pc,
    input  instr_valid
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: issues word reads for the PC, queues {pc, instr} pairs
// and hands them to decode; stalls the PC on lack of credit, flushes on redirect.
module instruction_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic                         clock,
  input logic                         reset,
  instruction_fetch_queue_if.master   bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  localparam logic [31:0]      SENTINEL = 32'hFFFF_FFFF;
  localparam logic [PTR_W:0]   FULL     = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W+1:0] LIMIT    = (PTR_W+2)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  fetch_entry_t     storage [DEPTH];
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             inflight;
  logic [31:0]      inflight_pc;

  logic [PTR_W+1:0] used;
  logic             space;
  logic             live_pc;
  logic             issue;
  logic             push;
  logic             pop;

  // The in-flight read already owns a slot, so it counts against credit.
  assign used    = {1'b0, count} + {{(PTR_W+1){1'b0}}, inflight};
  assign space   = used < LIMIT;
  assign live_pc = !reset && !bus.redirect && (bus.pc_addr != SENTINEL);
  assign issue   = live_pc && space;
  assign push    = inflight && !bus.redirect && !reset;
  assign pop     = bus.instr_valid && bus.instr_ready;

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = bus.pc_addr;
  assign bus.pc_stall    = live_pc && !space;
  assign bus.instr_valid = count != '0;
  assign bus.instr       = bus.instr_valid ? storage[rd_ptr].data : '0;
  assign bus.instr_pc    = bus.instr_valid ? storage[rd_ptr].pc : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect) begin
      count    <= '0;
      rd_ptr   <= wr_ptr;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= bus.pc_addr;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) storage[wr_ptr] <= '{pc: inflight_pc, data: bus.imem_rdata};
  end

  always_ff @(posedge clock) begin
    if (!reset && push) assert (count != FULL);
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Randomised bench for instruction_fetch_queue against a queue-based
// model of the fetch buffer, with a word memory returning addr+0x100.
module tb_instruction_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] SENT = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  instruction_fetch_queue_if bus ();

  instruction_fetch_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) bus.imem_rdata <= bus.imem_addr + 32'h100;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t        q[$];
  logic        pend;
  logic [31:0] pend_pc;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic redir,
                       input logic rdy, input logic [31:0] tgt);
    logic space, live, e_req, e_stall, e_valid;
    logic [31:0] e_instr, e_pc;
    ent_t e;
    reset           = rst;
    bus.redirect    = redir;
    bus.instr_ready = rdy;
    space   = (q.size() + int'(pend)) < DEPTH;
    live    = !rst && !redir && (bus.pc_addr != SENT);
    e_req   = live && space;
    e_stall = live && !space;
    e_valid = q.size() != 0;
    e_instr = e_valid ? q[0].data : 32'h0;
    e_pc    = e_valid ? q[0].pc : 32'h0;
    @(negedge clock);
    check("imem_req", {31'b0, bus.imem_req}, {31'b0, e_req});
    check("pc_stall", {31'b0, bus.pc_stall}, {31'b0, e_stall});
    check("imem_addr", bus.imem_addr, bus.pc_addr);
    check("instr_valid", {31'b0, bus.instr_valid}, {31'b0, e_valid});
    check("instr", bus.instr, e_instr);
    check("instr_pc", bus.instr_pc, e_pc);
    @(posedge clock);
    if (rst || redir) begin
      q.delete();
      pend = 1'b0;
    end else begin
      if (e_valid && rdy) void'(q.pop_front());
      if (pend) begin
        e.pc   = pend_pc;
        e.data = pend_pc + 32'h100;
        q.push_back(e);
      end
      check("model_occupancy", 32'(q.size() <= DEPTH), 32'd1);
      pend    = e_req;
      pend_pc = bus.pc_addr;
    end
    #1;
    if (rst) bus.pc_addr = SENT;
    else if (redir) bus.pc_addr = tgt;
    else if (bus.pc_addr == SENT) bus.pc_addr = 32'h0;
    else if (e_req) bus.pc_addr = bus.pc_addr + 32'h1;
  endtask

  initial begin
    pend            = 1'b0;
    pend_pc         = '0;
    bus.pc_addr     = SENT;
    bus.redirect    = 1'b0;
    bus.instr_ready = 1'b0;
    repeat (2) cycle(1'b1, 1'b0, 1'b1, 32'h0);
    repeat (12) cycle(1'b0, 1'b0, 1'b1, 32'h0);
    repeat (8) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (8) cycle(1'b0, 1'b0, 1'b1, 32'h0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h40);
    repeat (6) cycle(1'b0, 1'b0, 1'b1, 32'h0);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h0);
    repeat (8) cycle(1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 200) == 0, ($urandom % 16) == 0,
            ($urandom % 4) != 0, $urandom & 32'h0000_FFFF);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
